ram_pair_writer: RTL and testbench

Upstream write controller for the 256x32 dual-port multi-RAM. It accepts a burst command (base address, length), pulses the RAM clear, then takes a valid/ready stream of 32-bit words. Words are packed into pairs and written through both RAM ports in one cycle: port 1 gets the even offset, port 2 the odd offset. It also meets the RAM's split-phase write contract: a port enable is asserted in cycle k, and the address/data for that port are presented in cycle k+1 and written at the end of k+1.

---
 rtl/ram_pair_writer.sv | 229 ++++++++++++++++++++++
 tb/tb_ram_pair_writer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_pair_writer.sv
// Burst write controller for the dual-port RAM: packs a word stream into even/odd pairs
// and drives the RAM's split-phase contract (enable in cycle k, address/data in k+1).
module ram_pair_writer #(
   parameter int AW = 8,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cmd_go,
   input  logic [AW-1:0] cmd_base,
   input  logic [AW:0]   cmd_len,
   input  logic          s_valid,
   input  logic [DW-1:0] s_data,
   output logic          s_ready,
   output logic          busy,
   output logic          done,
   output logic          ram_start,
   output logic          ram_en1,
   output logic          ram_en2,
   output logic [AW-1:0] ram_addr1,
   output logic [AW-1:0] ram_addr2,
   output logic [DW-1:0] ram_din1,
   output logic [DW-1:0] ram_din2
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_FILL,
      S_DRAIN,
      S_DONE
   } state_t;

   localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};
   localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
   localparam logic [AW-1:0] PTR_TWO = {{(AW-2){1'b0}}, 2'd2};

   state_t          r_state;
   state_t          w_state_nxt;

   logic [AW:0]     r_len;
   logic [AW:0]     r_cnt;
   logic [AW-1:0]   r_ptr;

   logic [DW-1:0]   r_hold_data_p0;
   logic            r_hold_v_p0;

   logic            r_en1_p1;
   logic            r_en2_p1;
   logic [AW-1:0]   r_pend_addr1_p1;
   logic [AW-1:0]   r_pend_addr2_p1;
   logic [DW-1:0]   r_pend_din1_p1;
   logic [DW-1:0]   r_pend_din2_p1;

   logic [AW-1:0]   r_addr1_p2;
   logic [AW-1:0]   r_addr2_p2;
   logic [DW-1:0]   r_din1_p2;
   logic [DW-1:0]   r_din2_p2;

   logic            r_busy;
   logic            r_done;
   logic            r_start;

   logic            w_ready;
   logic            w_accept;
   logic            w_last;
   logic            w_issue_pair;
   logic            w_issue_single;
   logic            w_hold_load;
   logic            w_busy_nxt;
   logic            w_done_nxt;
   logic            w_start_nxt;
   logic [AW:0]     w_cnt_inc;
   logic [AW-1:0]   w_ptr_odd;

   // Accept/issue decode: the word that completes a pair or the burst goes straight to the RAM
   assign w_cnt_inc      = r_cnt + CNT_ONE;
   assign w_ptr_odd      = r_ptr + PTR_ONE;
   assign w_ready        = (r_state == S_FILL) && (r_cnt < r_len);
   assign w_accept       = w_ready && s_valid;
   assign w_last         = (w_cnt_inc == r_len);
   assign w_issue_pair   = w_accept && r_hold_v_p0;
   assign w_issue_single = w_accept && !r_hold_v_p0 && w_last;
   assign w_hold_load    = w_accept && !r_hold_v_p0 && !w_last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_busy_nxt  = 1'b0;
      w_done_nxt  = 1'b0;
      w_start_nxt = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (cmd_go) begin
               w_state_nxt = (cmd_len != '0) ? S_CLEAR : S_DONE;
            end
         end
         S_CLEAR: begin
            w_state_nxt = S_FILL;
         end
         S_FILL: begin
            if (w_accept && w_last) begin
               w_state_nxt = S_DRAIN;
            end
         end
         // The final enable is visible in the first DRAIN cycle; leave once its data phase is up
         S_DRAIN: begin
            if (!r_en1_p1) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
      w_busy_nxt  = (w_state_nxt == S_CLEAR) || (w_state_nxt == S_FILL) ||
                    (w_state_nxt == S_DRAIN);
      w_done_nxt  = (w_state_nxt == S_DONE);
      w_start_nxt = (w_state_nxt == S_CLEAR);
   end

   // Command latch, accept counter and pair pointer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_len   <= '0;
         r_cnt   <= '0;
         r_ptr   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_start <= 1'b0;
      end else begin
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
         r_start <= w_start_nxt;
         if ((r_state == S_IDLE) && cmd_go) begin
            r_len <= cmd_len;
            r_cnt <= '0;
            r_ptr <= cmd_base;
         end else begin
            if (w_accept) begin
               r_cnt <= w_cnt_inc;
            end
            if (w_issue_pair) begin
               r_ptr <= r_ptr + PTR_TWO;
            end
         end
      end
   end

   // p0: even-offset word waits here for its odd partner
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hold_data_p0 <= '0;
         r_hold_v_p0    <= 1'b0;
      end else if ((r_state == S_IDLE) && cmd_go) begin
         r_hold_v_p0 <= 1'b0;
      end else if (w_hold_load) begin
         r_hold_data_p0 <= s_data;
         r_hold_v_p0    <= 1'b1;
      end else if (w_issue_pair) begin
         r_hold_v_p0 <= 1'b0;
      end
   end

   // p1: enable phase; address/data staged for the following cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_en1_p1        <= 1'b0;
         r_en2_p1        <= 1'b0;
         r_pend_addr1_p1 <= '0;
         r_pend_addr2_p1 <= '0;
         r_pend_din1_p1  <= '0;
         r_pend_din2_p1  <= '0;
      end else begin
         r_en1_p1 <= w_issue_pair || w_issue_single;
         r_en2_p1 <= w_issue_pair;
         if (w_issue_pair) begin
            r_pend_addr1_p1 <= r_ptr;
            r_pend_din1_p1  <= r_hold_data_p0;
            r_pend_addr2_p1 <= w_ptr_odd;
            r_pend_din2_p1  <= s_data;
         end else if (w_issue_single) begin
            r_pend_addr1_p1 <= r_ptr;
            r_pend_din1_p1  <= s_data;
         end
      end
   end

   // p2: data phase; values persist until the next write on that port
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr1_p2 <= '0;
         r_addr2_p2 <= '0;
         r_din1_p2  <= '0;
         r_din2_p2  <= '0;
      end else begin
         if (r_en1_p1) begin
            r_addr1_p2 <= r_pend_addr1_p1;
            r_din1_p2  <= r_pend_din1_p1;
         end
         if (r_en2_p1) begin
            r_addr2_p2 <= r_pend_addr2_p1;
            r_din2_p2  <= r_pend_din2_p1;
         end
      end
   end

   assign s_ready   = w_ready;
   assign busy      = r_busy;
   assign done      = r_done;
   assign ram_start = r_start;
   assign ram_en1   = r_en1_p1;
   assign ram_en2   = r_en2_p1;
   assign ram_addr1 = r_addr1_p2;
   assign ram_addr2 = r_addr2_p2;
   assign ram_din1  = r_din1_p2;
   assign ram_din2  = r_din2_p2;

endmodule

// File: tb/tb_ram_pair_writer.sv
// Directed bench for ram_pair_writer with a behavioural split-phase 256x32 RAM model.
module tb_ram_pair_writer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_go;
   logic [7:0]  cmd_base;
   logic [8:0]  cmd_len;
   logic        s_valid;
   logic [31:0] s_data;
   logic        s_ready, busy, done, ram_start, ram_en1, ram_en2;
   logic [7:0]  ram_addr1, ram_addr2;
   logic [31:0] ram_din1, ram_din2;

   int n_tests = 0;
   int n_fail  = 0;

   int n_start = 0;
   int n_en1   = 0;
   int n_en2   = 0;
   int n_done  = 0;

   logic [31:0] mem [256] = '{default: 32'hDEADBEEF};
   logic        m_en1_d = 1'b0;
   logic        m_en2_d = 1'b0;
   logic [31:0] wdata [4];

   ram_pair_writer #(.AW(8), .DW(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_go    (cmd_go),
      .cmd_base  (cmd_base),
      .cmd_len   (cmd_len),
      .s_valid   (s_valid),
      .s_data    (s_data),
      .s_ready   (s_ready),
      .busy      (busy),
      .done      (done),
      .ram_start (ram_start),
      .ram_en1   (ram_en1),
      .ram_en2   (ram_en2),
      .ram_addr1 (ram_addr1),
      .ram_addr2 (ram_addr2),
      .ram_din1  (ram_din1),
      .ram_din2  (ram_din2)
   );

   always #5 clk = ~clk;

   // RAM: enable seen at one edge, address/data written at the next
   always @(posedge clk) begin
      if (ram_start) begin
         for (int i = 0; i < 32; i++) mem[i] <= 32'h0;
      end
      if (m_en1_d) mem[ram_addr1] <= ram_din1;
      if (m_en2_d) mem[ram_addr2] <= ram_din2;
      m_en1_d <= ram_en1;
      m_en2_d <= ram_en2;
      if (ram_start) n_start++;
      if (ram_en1)   n_en1++;
      if (ram_en2)   n_en2++;
      if (done)      n_done++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issues a command, streams wdata[] and returns the cycle number in which done is seen
   task automatic run_cmd(input logic [7:0] base, input logic [8:0] len, input int stall_after,
                          input int stall_cyc, input bit extra_go, output int done_cyc);
      int  acc;
      int  cyc;
      int  stall_left;
      bit  accepted;
      acc        = 0;
      stall_left = 0;
      done_cyc   = -1;
      cmd_base   = base;
      cmd_len    = len;
      cmd_go     = 1'b1;
      s_valid    = 1'b0;
      tick();
      cmd_go = 1'b0;
      cyc    = 1;
      while (cyc < 400 && done_cyc < 0) begin
         if (done) begin
            done_cyc = cyc;
         end else begin
            cmd_go = extra_go && (cyc == 3);
            if (stall_left > 0) begin
               s_valid = 1'b0;
               chk("stall_ready", s_ready, 1);
               stall_left--;
            end else if (acc < int'(len)) begin
               s_valid = 1'b1;
               s_data  = wdata[acc];
            end else begin
               s_valid = 1'b0;
            end
            accepted = s_valid && s_ready;
            tick();
            cyc++;
            if (accepted) begin
               acc++;
               if (acc == stall_after) stall_left = stall_cyc;
            end
         end
      end
      cmd_go  = 1'b0;
      s_valid = 1'b0;
   endtask

   initial begin
      int dc, s0, e1, e2, d0;
      rst_n    = 1'b0;
      cmd_go   = 1'b0;
      cmd_base = '0;
      cmd_len  = '0;
      s_valid  = 1'b0;
      s_data   = '0;
      tick();
      tick();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ready", s_ready, 0);
      chk("rst_start", ram_start, 0);
      chk("rst_en", {ram_en1, ram_en2}, 0);
      chk("rst_addr", {ram_addr1, ram_addr2}, 0);
      chk("rst_din1", ram_din1, 0);
      chk("rst_din2", ram_din2, 0);
      #2 rst_n = 1'b1;
      tick();

      // len=4 at 0x10, continuous stream, cycle-exact
      s0 = n_start; e1 = n_en1; e2 = n_en2; d0 = n_done;
      cmd_base = 8'h10; cmd_len = 9'd4; cmd_go = 1'b1;
      s_valid = 1'b1; s_data = 32'hA0;
      tick(); cmd_go = 1'b0;
      chk("t1_c1_busy", busy, 1);
      chk("t1_c1_start", ram_start, 1);
      chk("t1_c1_ready", s_ready, 0);
      chk("t1_c1_en1", ram_en1, 0);
      tick();
      chk("t1_c2_ready", s_ready, 1);
      chk("t1_c2_start", ram_start, 0);
      tick(); s_data = 32'hA1;
      chk("t1_c3_en1", ram_en1, 0);
      chk("t1_c3_ready", s_ready, 1);
      tick(); s_data = 32'hA2;
      chk("t1_c4_en", {ram_en1, ram_en2}, 2'b11);
      tick(); s_data = 32'hA3;
      chk("t1_c5_en", {ram_en1, ram_en2}, 2'b00);
      chk("t1_c5_addr1", ram_addr1, 8'h10);
      chk("t1_c5_din1", ram_din1, 32'hA0);
      chk("t1_c5_addr2", ram_addr2, 8'h11);
      chk("t1_c5_din2", ram_din2, 32'hA1);
      tick(); s_valid = 1'b0;
      chk("t1_c6_en", {ram_en1, ram_en2}, 2'b11);
      chk("t1_c6_ready", s_ready, 0);
      chk("t1_c6_busy", busy, 1);
      tick();
      chk("t1_c7_addr1", ram_addr1, 8'h12);
      chk("t1_c7_din1", ram_din1, 32'hA2);
      chk("t1_c7_addr2", ram_addr2, 8'h13);
      chk("t1_c7_din2", ram_din2, 32'hA3);
      chk("t1_c7_done", done, 0);
      tick();
      chk("t1_c8_done", done, 1);
      chk("t1_c8_busy", busy, 0);
      tick();
      chk("t1_c9_done", done, 0);
      chk("t1_starts", n_start - s0, 1);
      chk("t1_en1s", n_en1 - e1, 2);
      chk("t1_en2s", n_en2 - e2, 2);
      chk("t1_dones", n_done - d0, 1);
      chk("t1_mem10", mem[8'h10], 32'hA0);
      chk("t1_mem11", mem[8'h11], 32'hA1);
      chk("t1_mem12", mem[8'h12], 32'hA2);
      chk("t1_mem13", mem[8'h13], 32'hA3);

      // odd length: third word through port 1 only
      wdata = '{32'hB0, 32'hB1, 32'hB2, 32'h0};
      e1 = n_en1; e2 = n_en2; d0 = n_done;
      run_cmd(8'h20, 9'd3, -1, 0, 1'b0, dc);
      tick(); tick();
      chk("t2_done_cyc", dc, 7);
      chk("t2_en1s", n_en1 - e1, 2);
      chk("t2_en2s", n_en2 - e2, 1);
      chk("t2_dones", n_done - d0, 1);
      chk("t2_mem20", mem[8'h20], 32'hB0);
      chk("t2_mem21", mem[8'h21], 32'hB1);
      chk("t2_mem22", mem[8'h22], 32'hB2);
      chk("t2_mem23", mem[8'h23], 32'hDEADBEEF);

      // address wrap at 0xFF
      wdata = '{32'h11, 32'h22, 32'h0, 32'h0};
      run_cmd(8'hFF, 9'd2, -1, 0, 1'b0, dc);
      tick(); tick();
      chk("t3_done_cyc", dc, 6);
      chk("t3_memFF", mem[8'hFF], 32'h11);
      chk("t3_mem00", mem[8'h00], 32'h22);

      // 3-cycle s_valid gap after the first word
      wdata = '{32'hC0, 32'hC1, 32'hC2, 32'hC3};
      run_cmd(8'h40, 9'd4, 1, 3, 1'b0, dc);
      tick(); tick();
      chk("t4_done_cyc", dc, 11);
      chk("t4_mem40", mem[8'h40], 32'hC0);
      chk("t4_mem41", mem[8'h41], 32'hC1);
      chk("t4_mem42", mem[8'h42], 32'hC2);
      chk("t4_mem43", mem[8'h43], 32'hC3);

      // zero length
      s0 = n_start; e1 = n_en1; e2 = n_en2; d0 = n_done;
      run_cmd(8'h70, 9'd0, -1, 0, 1'b0, dc);
      chk("t5_busy", busy, 0);
      chk("t5_start", ram_start, 0);
      tick(); tick();
      chk("t5_done_cyc", dc, 1);
      chk("t5_starts", n_start - s0, 0);
      chk("t5_ens", (n_en1 - e1) + (n_en2 - e2), 0);
      chk("t5_dones", n_done - d0, 1);

      // cmd_go while busy is ignored
      wdata = '{32'hE0, 32'hE1, 32'h0, 32'h0};
      d0 = n_done;
      run_cmd(8'h30, 9'd2, -1, 0, 1'b1, dc);
      tick(); tick(); tick(); tick();
      chk("t6_done_cyc", dc, 6);
      chk("t6_dones", n_done - d0, 1);
      chk("t6_busy_after", busy, 0);
      chk("t6_mem30", mem[8'h30], 32'hE0);
      chk("t6_mem31", mem[8'h31], 32'hE1);

      // async reset after one accepted word
      cmd_base = 8'h50; cmd_len = 9'd4; cmd_go = 1'b1;
      s_valid = 1'b1; s_data = 32'hD0;
      tick(); cmd_go = 1'b0;
      tick();
      tick(); s_valid = 1'b0;
      chk("t7_busy_pre", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("t7_busy", busy, 0);
      chk("t7_ready", s_ready, 0);
      chk("t7_done", done, 0);
      chk("t7_start", ram_start, 0);
      chk("t7_en", {ram_en1, ram_en2}, 0);
      chk("t7_addr", {ram_addr1, ram_addr2}, 0);
      chk("t7_din1", ram_din1, 0);
      chk("t7_din2", ram_din2, 0);
      #3 rst_n = 1'b1;
      tick();
      chk("t7_idle_ready", s_ready, 0);
      chk("t7_idle_busy", busy, 0);
      wdata = '{32'hF0, 32'hF1, 32'h0, 32'h0};
      run_cmd(8'h60, 9'd2, -1, 0, 1'b0, dc);
      tick(); tick();
      chk("t7_done_cyc", dc, 6);
      chk("t7_mem60", mem[8'h60], 32'hF0);
      chk("t7_mem61", mem[8'h61], 32'hF1);
      chk("t7_mem50", mem[8'h50], 32'hDEADBEEF);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
